// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit sitting right after the ALU.
//
// Accepts one memory op at a time from EX, drives a single-outstanding
// valid/grant/rvalid data-memory port, and returns sign/zero-extended load
// data to writeback. EX is stalled through o_ready while an op is in flight.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), synchronous active-low reset
//   i_valid / o_ready         op handshake from EX
//   i_is_store, i_funct3      op kind and RV32I width/sign code
//   i_addr, i_store_data      effective address and rs2 value
//   i_rd                      load destination register
//   o_mem_req / i_mem_gnt     memory request handshake
//   o_mem_addr/we/be/wdata    word-aligned address, write enable, byte lanes, data
//   i_mem_rvalid/i_mem_rdata  read response
//   o_wb_valid/o_wb_rd/o_wb_data  load writeback (valid is a one-cycle pulse)
//   o_done                    one-cycle pulse on any retire (load, store, error)
//   o_err/o_err_addr          one-cycle pulse on misaligned/illegal op, plus address
module rv_lsu #(
   parameter int WIDTH   = 32,
   parameter int RD_BITS = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic               i_is_store,
   input  logic [2:0]         i_funct3,
   input  logic [WIDTH-1:0]   i_addr,
   input  logic [WIDTH-1:0]   i_store_data,
   input  logic [RD_BITS-1:0] i_rd,
   output logic               o_mem_req,
   input  logic               i_mem_gnt,
   output logic [WIDTH-1:0]   o_mem_addr,
   output logic               o_mem_we,
   output logic [3:0]         o_mem_be,
   output logic [WIDTH-1:0]   o_mem_wdata,
   input  logic               i_mem_rvalid,
   input  logic [WIDTH-1:0]   i_mem_rdata,
   output logic               o_wb_valid,
   output logic [RD_BITS-1:0] o_wb_rd,
   output logic [WIDTH-1:0]   o_wb_data,
   output logic               o_done,
   output logic               o_err,
   output logic [WIDTH-1:0]   o_err_addr
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   state_t               state_reg, state_next;

   // Captured op
   logic                 is_store_reg;
   logic [2:0]           funct3_reg;
   logic [WIDTH-1:0]     addr_reg;
   logic [WIDTH-1:0]     data_reg;
   logic [RD_BITS-1:0]   rd_reg;

   // Retire outputs
   logic                 wb_valid_reg, done_reg, err_reg;
   logic [RD_BITS-1:0]   wb_rd_reg;
   logic [WIDTH-1:0]     wb_data_reg, err_addr_reg;

   logic                 accept, funct3_illegal, misaligned, op_bad;
   logic [WIDTH-1:0]     rdata_shifted, load_ext;
   logic [3:0]           be_lanes;
   logic [WIDTH-1:0]     wdata_lanes;

   assign accept = (state_reg == IDLE) && i_valid;

   // Legality of the op presented by EX, evaluated in the accept cycle so a
   // bad op never leaves IDLE.
   always_comb begin
      funct3_illegal = 1'b1;
      case (i_funct3)
         3'b000, 3'b001, 3'b010: funct3_illegal = 1'b0;
         3'b100, 3'b101:         funct3_illegal = i_is_store;
         default:                funct3_illegal = 1'b1;
      endcase
   end

   // funct3[1:0] encodes size: 00 byte, 01 half, 10 word
   always_comb begin
      misaligned = 1'b0;
      case (i_funct3[1:0])
         2'b01:   misaligned = i_addr[0];
         2'b10:   misaligned = (i_addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   assign op_bad = funct3_illegal | misaligned;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept && !op_bad) state_next = REQ;
         REQ:  if (i_mem_gnt) state_next = is_store_reg ? IDLE : WAIT;
         WAIT: if (i_mem_rvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Load extraction from the returned word
   assign rdata_shifted = i_mem_rdata >> {addr_reg[1:0], 3'b000};

   always_comb begin
      load_ext = rdata_shifted;
      case (funct3_reg)
         3'b000:  load_ext = {{(WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b100:  load_ext = {{(WIDTH-8){1'b0}}, rdata_shifted[7:0]};
         3'b001:  load_ext = {{(WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b101:  load_ext = {{(WIDTH-16){1'b0}}, rdata_shifted[15:0]};
         default: load_ext = rdata_shifted;
      endcase
   end

   // Op capture and registered retire pulses
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         is_store_reg <= 1'b0;
         funct3_reg   <= 3'b000;
         addr_reg     <= '0;
         data_reg     <= '0;
         rd_reg       <= '0;
         wb_valid_reg <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         wb_rd_reg    <= '0;
         wb_data_reg  <= '0;
         err_addr_reg <= '0;
      end else begin
         wb_valid_reg <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         if (accept) begin
            is_store_reg <= i_is_store;
            funct3_reg   <= i_funct3;
            addr_reg     <= i_addr;
            data_reg     <= i_store_data;
            rd_reg       <= i_rd;
            if (op_bad) begin
               err_reg      <= 1'b1;
               done_reg     <= 1'b1;
               err_addr_reg <= i_addr;
            end
         end
         if (state_reg == REQ && i_mem_gnt && is_store_reg)
            done_reg <= 1'b1;
         if (state_reg == WAIT && i_mem_rvalid) begin
            wb_valid_reg <= 1'b1;
            done_reg     <= 1'b1;
            wb_rd_reg    <= rd_reg;
            wb_data_reg  <= load_ext;
         end
      end
   end

   // Per-lane byte enables and replicated write data. Only legal store sizes
   // reach REQ, and they are naturally aligned, so lane selection is simple.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign be_lanes[gi] = !is_store_reg
                             || (funct3_reg[1:0] == 2'b10)
                             || (funct3_reg[1:0] == 2'b00 && addr_reg[1:0] == LANE)
                             || (funct3_reg[1:0] == 2'b01 && addr_reg[1] == LANE[1]);
         assign wdata_lanes[gi*8 +: 8] =
              (funct3_reg[1:0] == 2'b00) ? data_reg[7:0]
            : (funct3_reg[1:0] == 2'b01) ? data_reg[8*(gi%2) +: 8]
            :                              data_reg[8*gi +: 8];
      end
   endgenerate

   // Outputs: memory port is only driven while a request is pending
   always_comb begin
      o_ready     = (state_reg == IDLE);
      o_mem_req   = (state_reg == REQ);
      o_mem_addr  = '0;
      o_mem_we    = 1'b0;
      o_mem_be    = 4'b0000;
      o_mem_wdata = '0;
      if (state_reg == REQ) begin
         o_mem_addr  = {addr_reg[WIDTH-1:2], 2'b00};
         o_mem_we    = is_store_reg;
         o_mem_be    = be_lanes;
         o_mem_wdata = is_store_reg ? wdata_lanes : '0;
      end
      o_wb_valid  = wb_valid_reg;
      o_wb_rd     = wb_rd_reg;
      o_wb_data   = wb_data_reg;
      o_done      = done_reg;
      o_err       = err_reg;
      o_err_addr  = err_addr_reg;
   end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed testbench for rv_lsu. Inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-computed.
module tb_rv_lsu;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic        i_is_store;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_store_data;
   logic [4:0]  i_rd;
   logic        o_mem_req;
   logic        i_mem_gnt;
   logic [31:0] o_mem_addr;
   logic        o_mem_we;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;
   logic        o_done;
   logic        o_err;
   logic [31:0] o_err_addr;

   int checks   = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   rv_lsu #(.WIDTH(32), .RD_BITS(5)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_is_store   (i_is_store),
      .i_funct3     (i_funct3),
      .i_addr       (i_addr),
      .i_store_data (i_store_data),
      .i_rd         (i_rd),
      .o_mem_req    (o_mem_req),
      .i_mem_gnt    (i_mem_gnt),
      .o_mem_addr   (o_mem_addr),
      .o_mem_we     (o_mem_we),
      .o_mem_be     (o_mem_be),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .o_wb_valid   (o_wb_valid),
      .o_wb_rd      (o_wb_rd),
      .o_wb_data    (o_wb_data),
      .o_done       (o_done),
      .o_err        (o_err),
      .o_err_addr   (o_err_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // Load with zero-wait memory: gnt in T+1, rvalid in T+2, writeback in T+3.
   // A junk rvalid is presented during REQ and must be ignored.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_data);
      i_valid = 1'b1; i_is_store = 1'b0; i_funct3 = f3; i_addr = addr;
      i_rd = rd; i_store_data = 32'h5555_5555;
      check({tag, "/ready"}, 32'(o_ready), 32'd1);
      tick();
      i_valid = 1'b0;
      check({tag, "/req"},   32'(o_mem_req), 32'd1);
      check({tag, "/maddr"}, o_mem_addr, exp_maddr);
      check({tag, "/be"},    32'(o_mem_be), 32'hF);
      check({tag, "/we"},    32'(o_mem_we), 32'd0);
      check({tag, "/wdata"}, o_mem_wdata, 32'd0);
      check({tag, "/busy"},  32'(o_ready), 32'd0);
      i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BAD_0BAD;
      tick();
      i_mem_gnt = 1'b0;
      check({tag, "/req_off"}, 32'(o_mem_req), 32'd0);
      check({tag, "/wait"},    32'(o_ready), 32'd0);
      check({tag, "/early"},   32'(o_wb_valid), 32'd0);
      i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
      tick();
      i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
      check({tag, "/wbv"},   32'(o_wb_valid), 32'd1);
      check({tag, "/done"},  32'(o_done), 32'd1);
      check({tag, "/err"},   32'(o_err), 32'd0);
      check({tag, "/data"},  o_wb_data, exp_data);
      check({tag, "/rd"},    32'(o_wb_rd), 32'(rd));
      check({tag, "/ready2"}, 32'(o_ready), 32'd1);
      tick();
      check({tag, "/wbv_pulse"},  32'(o_wb_valid), 32'd0);
      check({tag, "/done_pulse"}, 32'(o_done), 32'd0);
      check({tag, "/data_hold"},  o_wb_data, exp_data);
      $display("txn %s load f3=%0b addr=0x%08h rdata=0x%08h data=0x%08h", tag, f3, addr, rdata, o_wb_data);
   endtask

   // Store with gnt withheld for gnt_delay extra REQ cycles
   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_maddr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input int gnt_delay);
      i_valid = 1'b1; i_is_store = 1'b1; i_funct3 = f3; i_addr = addr;
      i_store_data = data; i_rd = 5'd0;
      check({tag, "/ready"}, 32'(o_ready), 32'd1);
      tick();
      i_valid = 1'b0;
      for (int i = 0; i <= gnt_delay; i++) begin
         check({tag, "/req"},   32'(o_mem_req), 32'd1);
         check({tag, "/maddr"}, o_mem_addr, exp_maddr);
         check({tag, "/be"},    32'(o_mem_be), 32'(exp_be));
         check({tag, "/wdata"}, o_mem_wdata, exp_wdata);
         check({tag, "/we"},    32'(o_mem_we), 32'd1);
         check({tag, "/busy"},  32'(o_ready), 32'd0);
         check({tag, "/nodone"}, 32'(o_done), 32'd0);
         if (i == gnt_delay) i_mem_gnt = 1'b1;
         tick();
      end
      i_mem_gnt = 1'b0;
      check({tag, "/done"},   32'(o_done), 32'd1);
      check({tag, "/wbv"},    32'(o_wb_valid), 32'd0);
      check({tag, "/err"},    32'(o_err), 32'd0);
      check({tag, "/req_off"}, 32'(o_mem_req), 32'd0);
      check({tag, "/ready2"}, 32'(o_ready), 32'd1);
      tick();
      check({tag, "/done_pulse"}, 32'(o_done), 32'd0);
      $display("txn %s store f3=%0b addr=0x%08h data=0x%08h be=%04b", tag, f3, addr, data, exp_be);
   endtask

   task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr);
      i_valid = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = addr;
      i_store_data = 32'hA5A5_A5A5; i_rd = 5'd3;
      tick();
      i_valid = 1'b0;
      check({tag, "/err"},   32'(o_err), 32'd1);
      check({tag, "/done"},  32'(o_done), 32'd1);
      check({tag, "/eaddr"}, o_err_addr, addr);
      check({tag, "/noreq"}, 32'(o_mem_req), 32'd0);
      check({tag, "/ready"}, 32'(o_ready), 32'd1);
      check({tag, "/wbv"},   32'(o_wb_valid), 32'd0);
      tick();
      check({tag, "/err_pulse"}, 32'(o_err), 32'd0);
      check({tag, "/noreq2"},    32'(o_mem_req), 32'd0);
      check({tag, "/eaddr_hold"}, o_err_addr, addr);
      $display("txn %s error st=%0b f3=%0b addr=0x%08h", tag, st, f3, addr);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "/ready"}, 32'(o_ready), 32'd1);
      check({tag, "/req"},   32'(o_mem_req), 32'd0);
      check({tag, "/maddr"}, o_mem_addr, 32'd0);
      check({tag, "/we"},    32'(o_mem_we), 32'd0);
      check({tag, "/be"},    32'(o_mem_be), 32'd0);
      check({tag, "/wdata"}, o_mem_wdata, 32'd0);
      check({tag, "/wbv"},   32'(o_wb_valid), 32'd0);
      check({tag, "/wbrd"},  32'(o_wb_rd), 32'd0);
      check({tag, "/wbdata"}, o_wb_data, 32'd0);
      check({tag, "/done"},  32'(o_done), 32'd0);
      check({tag, "/err"},   32'(o_err), 32'd0);
      check({tag, "/eaddr"}, o_err_addr, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_is_store = 1'b0; i_funct3 = 3'b000;
      i_addr = 32'd0; i_store_data = 32'd0; i_rd = 5'd0;
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
      @(negedge i_clk);
      tick();
      tick();
      check_idle_zero("reset");
      $display("txn reset initial");
      i_rst_n = 1'b1;
      tick();

      do_load("lw",  3'b010, 32'h0000_0100, 5'd7,  32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF);
      do_load("lb",  3'b000, 32'h0000_0103, 5'd9,  32'h80FF_0000, 32'h0000_0100, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h0000_0103, 5'd10, 32'h80FF_0000, 32'h0000_0100, 32'h0000_0080);
      do_load("lh",  3'b001, 32'h0000_0006, 5'd11, 32'h8001_1234, 32'h0000_0004, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h0000_0002, 5'd12, 32'h8001_1234, 32'h0000_0000, 32'h0000_8001);
      do_load("lb1", 3'b000, 32'h0000_0041, 5'd31, 32'h0000_7F00, 32'h0000_0040, 32'h0000_007F);

      do_store("sh",  3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 3);
      do_store("sb",  3'b000, 32'h0000_0013, 32'h1234_565A, 32'h0000_0010, 4'b1000, 32'h5A5A_5A5A, 0);
      do_store("sw",  3'b010, 32'h0000_0020, 32'h0102_0304, 32'h0000_0020, 4'b1111, 32'h0102_0304, 1);

      do_err("lw_mis", 1'b0, 3'b010, 32'h0000_0101);
      do_err("sb_f3",  1'b1, 3'b100, 32'h0000_0040);
      do_err("lh_mis", 1'b0, 3'b001, 32'h0000_0003);
      do_err("ld_f3",  1'b0, 3'b011, 32'h0000_0008);

      // Reset while a load is waiting for its data
      i_valid = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0300; i_rd = 5'd5;
      tick();
      i_valid = 1'b0; i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0;
      check("rst_inflight/wait", 32'(o_ready), 32'd0);
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      check_idle_zero("rst_inflight");
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
      tick();
      i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
      for (int i = 0; i < 3; i++) begin
         check("rst_late/wbv",    32'(o_wb_valid), 32'd0);
         check("rst_late/done",   32'(o_done), 32'd0);
         check("rst_late/wbdata", o_wb_data, 32'd0);
         check("rst_late/ready",  32'(o_ready), 32'd1);
         tick();
      end
      $display("txn reset during load wait");

      // Back-to-back SW then LW with i_valid held
      i_valid = 1'b1; i_is_store = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_0010;
      i_store_data = 32'hCAFE_F00D; i_rd = 5'd0;
      tick();
      check("b2b/sw_req", 32'(o_mem_req), 32'd1);
      check("b2b/sw_we",  32'(o_mem_we), 32'd1);
      i_is_store = 1'b0; i_rd = 5'd14; i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0;
      check("b2b/sw_done", 32'(o_done), 32'd1);
      check("b2b/ready",   32'(o_ready), 32'd1);
      check("b2b/gap",     32'(o_mem_req), 32'd0);
      tick();
      i_valid = 1'b0;
      check("b2b/lw_req",   32'(o_mem_req), 32'd1);
      check("b2b/lw_we",    32'(o_mem_we), 32'd0);
      check("b2b/lw_maddr", o_mem_addr, 32'h0000_0010);
      check("b2b/lw_done0", 32'(o_done), 32'd0);
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0;
      check("b2b/lw_wait", 32'(o_mem_req), 32'd0);
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
      tick();
      i_mem_rvalid = 1'b0;
      check("b2b/lw_wbv",  32'(o_wb_valid), 32'd1);
      check("b2b/lw_data", o_wb_data, 32'hCAFE_F00D);
      check("b2b/lw_rd",   32'(o_wb_rd), 32'd14);
      tick();
      check("b2b/idle_req", 32'(o_mem_req), 32'd0);
      $display("txn back-to-back sw/lw addr=0x00000010");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address, plus the store data, funct3 and destination register.
- Drives a single-outstanding valid/grant/rvalid data-memory port.
- Returns sign/zero-extended load data to writeback.
- Stalls the EX stage through o_ready while a transaction is in flight.

Parameters:
WIDTH, 32, data/address width; only 32 supported (byte-lane logic is fixed at 4 lanes)
RD_BITS, 5, width of destination register index

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  EX presents a memory op
o_ready  out  1  LSU can accept an op this cycle
i_is_store  in  1  1 = store, 0 = load
i_funct3  in  3  RV32I width/sign code
i_addr  in  WIDTH  effective address (ALU ADD result)
i_store_data  in  WIDTH  rs2 value
i_rd  in  RD_BITS  load destination
o_mem_req  out  1  memory request
i_mem_gnt  in  1  memory accepts request
o_mem_addr  out  WIDTH  word-aligned address
o_mem_we  out  1  write enable
o_mem_be  out  4  byte enables
o_mem_wdata  out  WIDTH  lane-replicated write data
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  WIDTH  read word
o_wb_valid  out  1  one-cycle pulse: load result valid
o_wb_rd  out  RD_BITS  load destination
o_wb_data  out  WIDTH  extended load data
o_done  out  1  one-cycle pulse: any op retired (load, store or error)
o_err  out  1  one-cycle pulse: misaligned or illegal funct3
o_err_addr  out  WIDTH  offending address

Behaviour:
- Single clock i_clk; reset synchronous, active-low on i_rst_n.
- Reset (i_rst_n=0 at a rising edge):
  - state to IDLE; all outputs 0 except o_ready=1.
  - Any in-flight transaction is abandoned.
  - An i_mem_rvalid arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - o_ready=1.
  - On i_valid, capture is_store, funct3, addr, store_data, rd.
  - Legal funct3 for loads: 000, 001, 010, 100, 101. Legal for stores: 000, 001, 010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Illegal or misaligned op: stay IDLE; next cycle o_err=1, o_done=1, o_err_addr=addr; no memory request is issued.
  - Legal op: go to REQ.
- REQ:
  - o_ready=0; o_mem_req=1.
  - o_mem_addr = {addr[31:2],2'b00}; o_mem_we = is_store.
  - o_mem_req, addr, we, be and wdata are held stable until i_mem_gnt.
  - On gnt, a store goes to IDLE with o_done=1 the next cycle.
  - On gnt, a load goes to WAIT.
  - i_mem_rvalid is ignored in REQ.
- WAIT:
  - o_ready=0.
  - On i_mem_rvalid, the extracted data is registered.
  - Next cycle: o_wb_valid=1, o_done=1, o_wb_rd=rd, o_wb_data valid; state returns to IDLE.
  - No timeout.
- Store byte lanes, with k = addr[1:0]:
  - SB: be = 4'b0001<<k; wdata = {4{data[7:0]}}.
  - SH: be = 4'b0011<<k; wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111; wdata = data.
  - Loads drive be = 4'b1111 and wdata = 0.
- Load extraction: s = i_mem_rdata >> (8*addr[1:0]).
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: s.
- Pulse rules:
  - o_wb_valid, o_done and o_err are registered, exactly one cycle wide.
  - o_wb_data, o_wb_rd and o_err_addr hold their values until the next retire.
- Back-to-back: in the cycle o_done pulses the state is already IDLE, so o_ready=1 and a new op may be accepted.
- Latency, accept at cycle T with zero-wait memory (gnt at T+1, rvalid at T+2):
  - Load: o_wb_valid at T+3.
  - Store: o_done at T+2.
  - Error: o_err at T+1.
- i_valid while o_ready=0 is not accepted; EX must hold its inputs.

Test Plan:
- LW addr 0x0000_0100; gnt at T+1; rvalid at T+2 with rdata 0xDEADBEEF -> o_mem_addr=0x100, be=1111, we=0; o_wb_valid at T+3, o_wb_data=0xDEADBEEF, o_wb_rd echoes i_rd.
- LB addr 0x103, rdata 0x80FF_0000 -> o_wb_data=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080. LH addr 0x006, rdata 0x8001_1234 -> 0xFFFF_8001.
- SH addr 0x202, data 0x1234_ABCD, gnt withheld 3 cycles -> o_mem_addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1, all stable and o_ready=0 throughout; o_done one cycle after gnt; o_wb_valid stays 0.
- LW addr 0x101 -> no o_mem_req; o_err=1 and o_done=1 at T+1, o_err_addr=0x101. SB with funct3=100 -> o_err likewise.
- Load in WAIT, i_rst_n=0 for one cycle, then rvalid 0xFFFF_FFFF -> all outputs 0 after reset, o_ready=1, o_wb_valid never asserts.
- Back-to-back SW 0x10 then LW 0x10 with i_valid held -> second op accepted in the cycle o_done pulses; second o_mem_req follows the next cycle; no cycle has two requests.
